// File: rtl/inst_queue_if.sv
// Fetch-to-decode instruction queue bus.
// slave: queue side; master: fetch/decode side.
interface inst_queue_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_inst;
  logic          full;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          ovf;

  modport slave (
    input  flush, if_valid, if_pc, if_inst,
    input  out_ready,
    output full, out_valid, out_pc, out_inst,
    output count, ovf
  );

  modport master (
    output flush, if_valid, if_pc, if_inst,
    output out_ready,
    input  full, out_valid, out_pc, out_inst,
    input  count, ovf
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction FIFO between fetch return and decode.
// Ports: clk, rst (async high), q (inst_queue_if.slave).
module inst_queue #(
  parameter int DEPTH     = 16,
  parameter int SLACK     = 2,
  parameter int FLUSH_LAT = 2
) (
  input logic        clk,
  input logic        rst,
  inst_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [3:0]    disc_cnt;
  logic          ovf_q;
  logic          pop;
  logic          push_req;
  logic          push;

  assign pop      = (cnt != '0) & q.out_ready
                  & ~q.flush;
  assign push_req = q.if_valid & ~q.flush
                  & (disc_cnt == 4'd0);
  // A full queue still accepts when a pop
  // frees the head slot in the same cycle.
  assign push     = push_req
                  & ((cnt < CW'(DEPTH)) | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      disc_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_req & ~push)
        ovf_q <= 1'b1;
      if (q.flush) begin
        cnt      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        disc_cnt <= 4'(FLUSH_LAT);
      end else begin
        cnt <= cnt + CW'(push) - CW'(pop);
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (disc_cnt != 4'd0)
          disc_cnt <= disc_cnt - 4'd1;
      end
    end
  end

  // Payload storage survives flush and reset;
  // only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{pc: q.if_pc,
                       inst: q.if_inst};
  end

  assign head        = mem[rd_ptr];
  assign q.out_valid = (cnt != '0);
  assign q.out_pc    = q.out_valid ? head.pc
                                   : 32'h0;
  assign q.out_inst  = q.out_valid ? head.inst
                                   : 32'h0;
  assign q.full      = (cnt >= CW'(DEPTH - SLACK));
  assign q.count     = cnt;
  assign q.ovf       = ovf_q;
endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
// DEPTH=16, SLACK=2, FLUSH_LAT=2.
module tb_inst_queue;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  inst_queue_if #(.DEPTH(16)) q ();

  inst_queue #(
    .DEPTH(16), .SLACK(2), .FLUSH_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q(q.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] pc,
                       input logic rdy);
    q.if_valid  = v;
    q.if_pc     = pc;
    q.if_inst   = pc ^ K;
    q.out_ready = rdy;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (q.count !== 5'd0 || q.out_valid !== 1'b0 ||
        q.out_pc !== 32'h0 || q.out_inst !== 32'h0 ||
        q.full !== 1'b0 || q.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: cnt=%0d v=%b pc=%h inst=%h full=%b ovf=%b, want all 0",
               q.count, q.out_valid, q.out_pc,
               q.out_inst, q.full, q.ovf);
    end
    #10 rst = 1'b0;
  endtask

  task automatic test_fill3();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0);
      cyc();
      checks++;
      if (q.count !== 5'(i + 1) ||
          q.out_pc !== 32'h0 ||
          q.out_inst !== K ||
          q.full !== 1'b0) begin
        errors++;
        $display("FAIL fill3[%0d]: cnt=%0d pc=%h inst=%h full=%b, want cnt=%0d pc=0 inst=%h full=0",
                 i, q.count, q.out_pc, q.out_inst,
                 q.full, i + 1, K);
      end
    end
    drive(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hC, 1'b0);
    cyc();
    drive(1'b1, 32'h10, 1'b0);
    cyc();
    checks++;
    if (q.count !== 5'd5) begin
      errors++;
      $display("FAIL flush_pre: cnt=%0d want 5",
               q.count);
    end
    q.flush = 1'b1;
    drive(1'b1, 32'h50, 1'b1);
    cyc();
    q.flush = 1'b0;
    checks++;
    if (q.count !== 5'd0 || q.out_valid !== 1'b0 ||
        q.out_pc !== 32'h0) begin
      errors++;
      $display("FAIL flush_empty: cnt=%0d v=%b pc=%h, want 0 0 0",
               q.count, q.out_valid, q.out_pc);
    end
    drive(1'b1, 32'h100, 1'b0);
    cyc();
    checks++;
    if (q.count !== 5'd0 || q.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_disc1: cnt=%0d v=%b, want 0 0",
               q.count, q.out_valid);
    end
    drive(1'b1, 32'h104, 1'b0);
    cyc();
    checks++;
    if (q.count !== 5'd0) begin
      errors++;
      $display("FAIL flush_disc2: cnt=%0d want 0",
               q.count);
    end
    drive(1'b1, 32'h200, 1'b0);
    cyc();
    checks++;
    if (q.count !== 5'd1 || q.out_pc !== 32'h200 ||
        q.out_inst !== (32'h200 ^ K) ||
        q.ovf !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: cnt=%0d pc=%h inst=%h ovf=%b, want 1 200 %h 0",
               q.count, q.out_pc, q.out_inst, q.ovf,
               32'h200 ^ K);
    end
    drive(1'b0, 32'h0, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (q.count !== 5'd0) begin
      errors++;
      $display("FAIL flush_drain: cnt=%0d want 0",
               q.count);
    end
  endtask

  task automatic test_full_ovf();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 1'b0);
      cyc();
      checks++;
      if (q.count !== 5'(i + 1) ||
          q.full !== (i + 1 >= 14) ||
          q.ovf !== 1'b0 ||
          q.out_pc !== 32'h400) begin
        errors++;
        $display("FAIL full_fill[%0d]: cnt=%0d full=%b ovf=%b pc=%h, want %0d %b 0 400",
                 i, q.count, q.full, q.ovf, q.out_pc,
                 i + 1, (i + 1 >= 14));
      end
    end
    drive(1'b1, 32'h4FC, 1'b0);
    cyc();
    checks++;
    if (q.count !== 5'd16 || q.ovf !== 1'b1 ||
        q.out_pc !== 32'h400) begin
      errors++;
      $display("FAIL ovf_drop: cnt=%0d ovf=%b pc=%h, want 16 1 400",
               q.count, q.ovf, q.out_pc);
    end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] exp;
    drive(1'b1, 32'h1000, 1'b1);
    cyc();
    checks++;
    if (q.count !== 5'd16 || q.out_pc !== 32'h404 ||
        q.ovf !== 1'b1 || q.full !== 1'b1) begin
      errors++;
      $display("FAIL full_pp: cnt=%0d pc=%h ovf=%b full=%b, want 16 404 1 1",
               q.count, q.out_pc, q.ovf, q.full);
    end
    drive(1'b0, 32'h0, 1'b1);
    for (int j = 1; j <= 15; j++) begin
      cyc();
      exp = (j < 15) ? 32'h400 + 32'(4 * (1 + j))
                     : 32'h1000;
      checks++;
      if (q.count !== 5'(16 - j) || q.out_pc !== exp) begin
        errors++;
        $display("FAIL wrap_drain[%0d]: cnt=%0d pc=%h, want %0d %h",
                 j, q.count, q.out_pc, 16 - j, exp);
      end
    end
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (q.count !== 5'd0 || q.out_pc !== 32'h0 ||
        q.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_empty: cnt=%0d pc=%h v=%b, want 0 0 0",
               q.count, q.out_pc, q.out_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc;
    for (int i = 0; i < 40; i++) begin
      pc = 32'h2000 + 32'(4 * i);
      drive(1'b1, pc, 1'b1);
      cyc();
      checks++;
      if (q.count !== 5'd1 || q.out_pc !== pc ||
          q.out_inst !== (pc ^ K)) begin
        errors++;
        $display("FAIL stream[%0d]: cnt=%0d pc=%h inst=%h, want 1 %h %h",
                 i, q.count, q.out_pc, q.out_inst,
                 pc, pc ^ K);
      end
    end
    drive(1'b0, 32'h0, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (q.count !== 5'd0) begin
      errors++;
      $display("FAIL stream_end: cnt=%0d want 0",
               q.count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 1'b0);
      cyc();
    end
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (q.count !== 5'd7 || q.ovf !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: cnt=%0d ovf=%b, want 7 1",
               q.count, q.ovf);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (q.count !== 5'd0 || q.out_valid !== 1'b0 ||
        q.out_pc !== 32'h0 || q.out_inst !== 32'h0 ||
        q.full !== 1'b0 || q.ovf !== 1'b0) begin
      errors++;
      $display("FAIL arst: cnt=%0d v=%b pc=%h inst=%h full=%b ovf=%b, want all 0",
               q.count, q.out_valid, q.out_pc,
               q.out_inst, q.full, q.ovf);
    end
    #2 rst = 1'b0;
    drive(1'b1, 32'h3100, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (q.count !== 5'd1 || q.out_pc !== 32'h3100 ||
        q.out_inst !== (32'h3100 ^ K) ||
        q.ovf !== 1'b0) begin
      errors++;
      $display("FAIL arst_post: cnt=%0d pc=%h inst=%h ovf=%b, want 1 3100 %h 0",
               q.count, q.out_pc, q.out_inst, q.ovf,
               32'h3100 ^ K);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    q.flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    test_reset();
    test_fill3();
    test_flush();
    test_full_ovf();
    test_full_pushpop();
    test_stream();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch path and decode/dispatch. It captures each instruction returned by instruction memory for the PC issued by the PC register and buffers entries in a FIFO. It presents entries in order to the decoder with a valid/ready handshake. It drives the PC register's `stall` input early enough to absorb fetches already in flight. On a branch misprediction it empties itself and discards the wrong-path returns that are still in flight.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, at least 4.
- `SLACK`, 2: free entries reserved for in-flight fetches; must satisfy 1 ≤ SLACK < DEPTH.
- `FLUSH_LAT`, 2: cycles after the flush cycle during which returning fetches are discarded; range 0..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `flush`  in  1: misprediction flush, the same signal that drives the PC register.
- `if_valid`  in  1: instruction memory returns a fetch this cycle.
- `if_pc`  in  32: PC of the returned fetch.
- `if_inst`  in  32: instruction word of the returned fetch.
- `full`  out  1: occupancy threshold reached; drives the PC register `stall`.
- `out_valid`  out  1: the head entry is valid.
- `out_pc`  out  32: PC of the head entry.
- `out_inst`  out  32: instruction word of the head entry.
- `out_ready`  in  1: the decoder accepts the head entry this cycle.
- `count`  out  log2(DEPTH)+1: number of occupied entries.
- `ovf`  out  1: sticky overflow flag; set when a push is dropped for lack of space.

## Operation
- Storage is a circular buffer of {pc, inst} with `rd_ptr` and `wr_ptr`, each log2(DEPTH) bits, wrapping modulo DEPTH. An occupancy counter `cnt` (0..DEPTH) is held separately.
- pop = out_valid & out_ready & !flush.
- push_req = if_valid & !flush & (disc_cnt == 0).
- push = push_req & ((cnt < DEPTH) | pop). Pushing into a full queue is allowed when a pop happens in the same cycle.
- If push_req & !push, the fetch is dropped and `ovf` is set. `ovf` clears only on `rst`; `flush` does not clear it.
- The counter update is cnt + push − pop. A simultaneous push and pop leaves `cnt` unchanged and advances both pointers.
- `out_valid` = (cnt != 0). `out_pc` and `out_inst` show the entry at `rd_ptr` when valid, and 0 when empty.
- `full` = (cnt ≥ DEPTH − SLACK), decoded combinationally from the registered `cnt`.
- `count` = `cnt`.
- Flush handling:
  - In the flush cycle, `cnt`, `rd_ptr` and `wr_ptr` are set to 0.
  - Any push or pop presented in that cycle is ignored.
  - `disc_cnt` is loaded with FLUSH_LAT.
- Discard window: while `disc_cnt` ≠ 0, it decrements by 1 per cycle and every `if_valid` is silently discarded. These discards do not set `ovf`.
- A `flush` that arrives during an active discard window reloads `disc_cnt` to FLUSH_LAT.
- Stored contents are not cleared on flush; only pointers and count are reset.

## Timing
- Reset (asynchronous, immediate): cnt=0, rd_ptr=0, wr_ptr=0, disc_cnt=0, ovf=0. Outputs: out_valid=0, out_pc=0, out_inst=0, full=0, count=0.
- Push-to-output latency is 1 cycle: an entry pushed at edge N appears on `out_*` after edge N, if it is at the head.
- There is no combinational path from `if_*` or `out_ready` to any output.
- `full` rises in the cycle after the push that brings `cnt` to DEPTH−SLACK. That push is therefore the one that makes `full` assert.
- With the PC register's one-cycle response plus one cycle of memory latency, SLACK=2 absorbs every in-flight return without overflow.
- A flush at edge N gives empty outputs after N. With FLUSH_LAT=2, `if_valid` is discarded in cycles N+1 and N+2, and the first accepted return is at cycle N+3.
- A flush coinciding with `out_ready` does not pop; the head entry is lost along with the rest of the queue.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.

## Test plan
- Reset, then push PCs 0x0, 0x4, 0x8 on consecutive cycles with out_ready=0 → count steps 1,2,3; out_pc=0x0 holds; full=0.
- Push 14 entries with out_ready=0 (DEPTH=16, SLACK=2) → full=1 in the cycle after the 14th push. Two further pushes are accepted to reach count=16 with ovf=0. A 17th push is dropped and sets ovf=1.
- With count=16, assert if_valid and out_ready together → count stays 16, the head advances, and the new PC is stored at the wrapped tail. ovf is unchanged.
- Fill 5 entries, then flush → count=0 and out_valid=0 next cycle. if_valid with PC 0x100 and 0x104 in the two following cycles is discarded. PC 0x200 on the third cycle is accepted and appears on out_pc.
- Stream 40 pushes with out_ready=1 continuously → out_pc follows the input sequence one cycle late, with no gaps across pointer wrap; count stays at most 1.
- Assert rst asynchronously mid-stream with count=7 and ovf=1 → all outputs reach their reset values before the next clock edge. After release, the first push appears normally.
